// File: rtl/song_player_pkg.sv
// Shared constants for the autoplay song sequencer: note indices, ROM entry
// layout, the note-to-frequency lookup and the sequencer state encoding.
package song_player_pkg;

  localparam int NOTE_W  = 5;
  localparam int DUR_W   = 3;
  localparam int ENTRY_W = NOTE_W + DUR_W;
  localparam int ADDR_W  = 5;
  localparam int FREQ_W  = 11;

  localparam logic [FREQ_W-1:0] FREQ_SILENT = 11'd1;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 5'd1;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 5'd2;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 5'd3;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 5'd4;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 5'd5;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 5'd6;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 5'd7;
  localparam logic [NOTE_W-1:0] NOTE_C5   = 5'd8;
  localparam logic [NOTE_W-1:0] NOTE_D5   = 5'd9;
  localparam logic [NOTE_W-1:0] NOTE_E5   = 5'd10;
  localparam logic [NOTE_W-1:0] NOTE_F5   = 5'd11;
  localparam logic [NOTE_W-1:0] NOTE_G5   = 5'd12;
  localparam logic [NOTE_W-1:0] NOTE_A5   = 5'd13;
  localparam logic [NOTE_W-1:0] NOTE_B5   = 5'd14;
  localparam logic [NOTE_W-1:0] NOTE_C6   = 5'd15;
  localparam logic [NOTE_W-1:0] NOTE_D6   = 5'd16;
  localparam logic [NOTE_W-1:0] NOTE_E6   = 5'd17;
  localparam logic [NOTE_W-1:0] NOTE_F6   = 5'd18;
  localparam logic [NOTE_W-1:0] NOTE_G6   = 5'd19;
  localparam logic [NOTE_W-1:0] NOTE_A6   = 5'd20;
  localparam logic [NOTE_W-1:0] NOTE_B6   = 5'd21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    NOTE = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Note index to tone frequency in Hz; rests and unused indices are silent.
  function automatic logic [FREQ_W-1:0] freq_lut(input logic [NOTE_W-1:0] n);
    logic [FREQ_W-1:0] f;
    case (n)
      5'd1:    f = 11'd262;
      5'd2:    f = 11'd294;
      5'd3:    f = 11'd330;
      5'd4:    f = 11'd349;
      5'd5:    f = 11'd392;
      5'd6:    f = 11'd440;
      5'd7:    f = 11'd494;
      5'd8:    f = 11'd523;
      5'd9:    f = 11'd587;
      5'd10:   f = 11'd659;
      5'd11:   f = 11'd698;
      5'd12:   f = 11'd784;
      5'd13:   f = 11'd880;
      5'd14:   f = 11'd988;
      5'd15:   f = 11'd1047;
      5'd16:   f = 11'd1175;
      5'd17:   f = 11'd1319;
      5'd18:   f = 11'd1397;
      5'd19:   f = 11'd1568;
      5'd20:   f = 11'd1760;
      5'd21:   f = 11'd1976;
      default: f = FREQ_SILENT;
    endcase
    return f;
  endfunction

  // Pack a {note, duration} ROM entry.
  function automatic logic [ENTRY_W-1:0] mk_entry(input logic [NOTE_W-1:0] n,
                                                  input logic [DUR_W-1:0]  d);
    return {n, d};
  endfunction

endpackage

// File: rtl/song_player_rom.sv
// Combinational song ROM. SONG_SEL=0 is a short test song, SONG_SEL=1 the
// production tune. Unlisted addresses hold end markers (dur=0).
module song_rom
  import song_player_pkg::*;
#(
  parameter int SONG_SEL = 1
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  // Address decode for the selected song.
  always_comb begin
    entry = '0;
    if (SONG_SEL == 0) begin
      case (addr)
        5'd0:    entry = mk_entry(NOTE_C4,   3'd2);
        5'd1:    entry = mk_entry(NOTE_REST, 3'd1);
        5'd2:    entry = mk_entry(NOTE_G4,   3'd1);
        default: entry = mk_entry(NOTE_REST, 3'd0);
      endcase
    end else begin
      case (addr)
        5'd0:    entry = mk_entry(NOTE_C5,   3'd2);
        5'd1:    entry = mk_entry(NOTE_C5,   3'd2);
        5'd2:    entry = mk_entry(NOTE_G5,   3'd2);
        5'd3:    entry = mk_entry(NOTE_G5,   3'd2);
        5'd4:    entry = mk_entry(NOTE_A5,   3'd2);
        5'd5:    entry = mk_entry(NOTE_A5,   3'd2);
        5'd6:    entry = mk_entry(NOTE_G5,   3'd4);
        5'd7:    entry = mk_entry(NOTE_F5,   3'd2);
        5'd8:    entry = mk_entry(NOTE_F5,   3'd2);
        5'd9:    entry = mk_entry(NOTE_E5,   3'd2);
        5'd10:   entry = mk_entry(NOTE_E5,   3'd2);
        5'd11:   entry = mk_entry(NOTE_D5,   3'd2);
        5'd12:   entry = mk_entry(NOTE_D5,   3'd2);
        5'd13:   entry = mk_entry(NOTE_C5,   3'd4);
        5'd14:   entry = mk_entry(NOTE_REST, 3'd4);
        default: entry = mk_entry(NOTE_REST, 3'd0);
      endcase
    end
  end

endmodule

// File: rtl/song_player.sv
// Autoplay note sequencer: walks the song ROM and drives the melody
// generator frequency, with an articulation gap after every entry.
module song_player
  import song_player_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 12_500_000,
  parameter int unsigned GAP_TICKS      = 1_000_000,
  parameter int unsigned SONG_LEN       = 32,
  parameter int          SONG_SEL       = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [FREQ_W-1:0] frequency,
  output logic [NOTE_W-1:0] note_idx,
  output logic              busy,
  output logic              done
);

  localparam int UW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [UW-1:0]     UNIT_LAST = UW'(TICKS_PER_UNIT - 1);
  localparam logic [GW-1:0]     GAP_LAST  = GW'(GAP_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [DUR_W-1:0]    dur;
  logic [UW-1:0]       unit_cnt;
  logic [DUR_W-1:0]    unit_num;
  logic [GW-1:0]       gap_cnt;
  logic [ENTRY_W-1:0]  entry;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  song_rom #(.SONG_SEL(SONG_SEL)) u_rom (
    .addr  (addr),
    .entry (entry)
  );

  assign rom_note = entry[ENTRY_W-1:DUR_W];
  assign rom_dur  = entry[DUR_W-1:0];

  // Sequencer FSM with registered outputs; stop overrides every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      dur       <= '0;
      unit_cnt  <= '0;
      unit_num  <= '0;
      gap_cnt   <= '0;
      frequency <= FREQ_SILENT;
      note_idx  <= NOTE_REST;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        addr      <= '0;
        unit_cnt  <= '0;
        unit_num  <= '0;
        gap_cnt   <= '0;
        frequency <= FREQ_SILENT;
        note_idx  <= NOTE_REST;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            frequency <= FREQ_SILENT;
            note_idx  <= NOTE_REST;
            if (start) begin
              state <= LOAD;
              addr  <= '0;
              busy  <= 1'b1;
            end
          end
          LOAD: begin
            if (rom_dur == '0) begin
              // An end marker at address 0 never loops, so an empty song
              // cannot spin in LOAD forever.
              if (loop_en && addr != '0) begin
                addr <= '0;
              end else begin
                state <= IDLE;
                addr  <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state     <= NOTE;
              dur       <= rom_dur;
              unit_cnt  <= '0;
              unit_num  <= '0;
              frequency <= freq_lut(rom_note);
              note_idx  <= rom_note;
            end
          end
          NOTE: begin
            if (unit_cnt == UNIT_LAST) begin
              unit_cnt <= '0;
              if (unit_num == dur - 3'd1) begin
                state     <= GAP;
                unit_num  <= '0;
                gap_cnt   <= '0;
                frequency <= FREQ_SILENT;
                note_idx  <= NOTE_REST;
              end else begin
                unit_num <= unit_num + 3'd1;
              end
            end else begin
              unit_cnt <= unit_cnt + 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              if (addr == ADDR_LAST) begin
                // Running off the end of the ROM behaves like an end marker.
                if (loop_en) begin
                  state <= LOAD;
                  addr  <= '0;
                end else begin
                  state <= IDLE;
                  addr  <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                state <= LOAD;
                addr  <= addr + 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Scoreboard bench for song_player with the short test song and tiny timers.
module tb_song_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        loop_en;
  logic [10:0] frequency;
  logic [4:0]  note_idx;
  logic        busy;
  logic        done;

  song_player #(
    .TICKS_PER_UNIT (4),
    .GAP_TICKS      (2),
    .SONG_LEN       (32),
    .SONG_SEL       (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .frequency (frequency),
    .note_idx  (note_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] freq;
    logic [4:0]  note;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t  exp_q[$];
  int    scn_q[$];
  int    cyc_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    scn    = 0;
  string scn_name[7] = '{"reset_idle", "full_song", "loop", "stop",
                         "replay", "start_stop_idle", "rst_mid"};

  function automatic exp_t mk(input int f, input int n, input bit b, input bit d);
    exp_t e;
    e.freq = 11'(f);
    e.note = 5'(n);
    e.busy = b;
    e.done = d;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk(1, 0, 1'b0, 1'b0);
  endfunction

  // Hand-derived timeline of the test song, d = cycles since start cycle.
  function automatic exp_t song_ref(input int d_in, input bit lp);
    int d;
    d = d_in;
    if (d < 1) return idle_exp();
    if (!lp) begin
      if (d >= 27) return mk(1, 0, 1'b0, d == 27);
    end else begin
      while (d >= 27) d = d - 26;
    end
    if (d == 1)  return mk(1, 0, 1'b1, 1'b0);
    if (d <= 9)  return mk(262, 1, 1'b1, 1'b0);
    if (d <= 19) return mk(1, 0, 1'b1, 1'b0);
    if (d <= 23) return mk(392, 5, 1'b1, 1'b0);
    return mk(1, 0, 1'b1, 1'b0);
  endfunction

  // Drive inputs for the coming cycle and queue the outputs required in it.
  task automatic step(input bit st, input bit sp, input bit r, input bit lp,
                      input exp_t e, input int c);
    @(posedge clk);
    #1;
    start   = st;
    stop    = sp;
    rst     = r;
    loop_en = lp;
    exp_q.push_back(e);
    scn_q.push_back(scn);
    cyc_q.push_back(c);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      int   s;
      int   c;
      e = exp_q.pop_front();
      s = scn_q.pop_front();
      c = cyc_q.pop_front();
      a = {frequency, note_idx, busy, done};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got freq=%0d note=%0d busy=%0b done=%0b, want freq=%0d note=%0d busy=%0b done=%0b",
                 scn_name[s], c, a.freq, a.note, a.busy, a.done,
                 e.freq, e.note, e.busy, e.done);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held for one more cycle, then 20 idle cycles.
    scn = 0;
    step(0, 0, 1, 0, idle_exp(), -1);
    for (int c = 0; c < 20; c++) step(0, 0, 0, 0, idle_exp(), c);

    scn = 1;
    for (int c = 0; c < 32; c++) step(c == 0, 0, 0, 0, song_ref(c, 1'b0), c);

    scn = 2;
    for (int c = 0; c < 51; c++) step(c == 0, 0, 0, 1, song_ref(c, 1'b1), c);
    step(0, 1, 0, 1, song_ref(51, 1'b1), 51);
    for (int c = 52; c < 56; c++) step(0, 0, 0, 0, idle_exp(), c);

    scn = 3;
    for (int c = 0; c < 13; c++)
      step(c == 0, c == 5, 0, 0, (c <= 5) ? song_ref(c, 1'b0) : idle_exp(), c);

    scn = 4;
    for (int c = 0; c < 30; c++) step(c == 0, 0, 0, 0, song_ref(c, 1'b0), c);

    scn = 5;
    for (int c = 0; c < 10; c++) step(c == 0, c == 0, 0, 0, idle_exp(), c);
    for (int c = 0; c < 32; c++)
      step(c == 0 || c == 4, 0, 0, 0, song_ref(c, 1'b0), c);

    scn = 6;
    for (int c = 0; c < 26; c++) begin
      exp_t e;
      if (c <= 6)      e = song_ref(c, 1'b0);
      else if (c <= 9) e = idle_exp();
      else             e = song_ref(c - 10, 1'b0);
      step(c == 0 || c == 10, 0, c == 6, 0, e, c);
    end

    // Let the monitor drain, bounded.
    begin
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(posedge clk);
        guard++;
      end
      if (exp_q.size() > 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
